// File: rtl/fc2_result_store_if.sv
// Port-A bus of the result BRAM as driven by fc2_result_store.
// master drives the write port; slave is the BRAM side.
interface fc2_result_store_if #(
  parameter int ADDR_W    = 15,
  parameter int DATA_SIZE = 8
);
  logic                 result_bram_ena;
  logic                 result_bram_wea;
  logic [ADDR_W-1:0]    result_bram_addra;
  logic [DATA_SIZE-1:0] result_bram_dina;

  modport master (
    output result_bram_ena,
    output result_bram_wea,
    output result_bram_addra,
    output result_bram_dina
  );

  modport slave (
    input result_bram_ena,
    input result_bram_wea,
    input result_bram_addra,
    input result_bram_dina
  );
endinterface

// File: rtl/fc2_result_store.sv
// Writes the packed FC2 output vector byte-by-byte into the result BRAM from FC2_RESULT_BASE.
// Optional macro FC2_ARGMAX_EN adds a signed running argmax reported on max_index.
module fc2_result_store #(
  parameter int OUTPUT_NODE     = 10,
  parameter int DATA_SIZE       = 8,
  parameter int FC2_RESULT_BASE = 18900,
  parameter int ADDR_W          = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             store_en,
  input  logic [DATA_SIZE*OUTPUT_NODE-1:0] data_in,
  fc2_result_store_if.master               bram,
  output logic                             store_busy,
  output logic                             store_finish
`ifdef FC2_ARGMAX_EN
  ,
  output logic [3:0]                       max_index
`endif
);

  localparam int VEC_W = DATA_SIZE * OUTPUT_NODE;
  localparam int CNT_W = $clog2(OUTPUT_NODE + 1);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(FC2_RESULT_BASE);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(OUTPUT_NODE);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_WRITE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VEC_W-1:0]     shadow_q, shadow_d;
  logic                 ena_q, ena_d;
  logic                 wea_q, wea_d;
  logic [ADDR_W-1:0]    addra_q, addra_d;
  logic [DATA_SIZE-1:0] dina_q, dina_d;
  logic                 busy_q, busy_d;
  logic                 finish_q, finish_d;

  // The shadow shifts left after each write, so the byte to send is always at the top.
  logic [DATA_SIZE-1:0] cur_byte;
  assign cur_byte = shadow_q[VEC_W-1 -: DATA_SIZE];

`ifdef FC2_ARGMAX_EN
  logic signed [DATA_SIZE-1:0] cur_byte_s;
  logic signed [DATA_SIZE-1:0] run_max_q, run_max_d;
  logic [3:0]                  run_idx_q, run_idx_d;
  logic [3:0]                  max_index_q, max_index_d;
  assign cur_byte_s = signed'(cur_byte);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      ena_q    <= 1'b0;
      wea_q    <= 1'b0;
      addra_q  <= '0;
      dina_q   <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ena_q    <= ena_d;
      wea_q    <= wea_d;
      addra_q  <= addra_d;
      dina_q   <= dina_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

`ifdef FC2_ARGMAX_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max_q   <= '0;
      run_idx_q   <= '0;
      max_index_q <= '0;
    end else begin
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      max_index_q <= max_index_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ena_d    = 1'b0;
    wea_d    = 1'b0;
    addra_d  = addra_q;
    dina_d   = dina_q;
    busy_d   = 1'b0;
    finish_d = 1'b0;
`ifdef FC2_ARGMAX_EN
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_index_d = max_index_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (store_en) begin
          state_d = S_LATCH;
          busy_d  = 1'b1;
        end
      end
      S_LATCH: begin
        if (!store_en) begin
          state_d = S_IDLE;
        end else begin
          shadow_d = data_in;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        // The cycle after the last byte closes the burst so ena drops with finish rising.
        if (!store_en) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_C) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
`ifdef FC2_ARGMAX_EN
          max_index_d = run_idx_q;
`endif
        end else begin
          ena_d    = 1'b1;
          wea_d    = 1'b1;
          addra_d  = BASE_A + ADDR_W'(cnt_q);
          dina_d   = cur_byte;
          shadow_d = shadow_q << DATA_SIZE;
          cnt_d    = cnt_q + CNT_W'(1);
          busy_d   = 1'b1;
`ifdef FC2_ARGMAX_EN
          // Strict greater-than keeps the lower index on ties.
          if (cnt_q == '0 || cur_byte_s > run_max_q) begin
            run_max_d = cur_byte_s;
            run_idx_d = 4'(cnt_q);
          end
`endif
        end
      end
      S_DONE: begin
        if (store_en) begin
          finish_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bram.result_bram_ena   = ena_q;
  assign bram.result_bram_wea   = wea_q;
  assign bram.result_bram_addra = addra_q;
  assign bram.result_bram_dina  = dina_q;
  assign store_busy             = busy_q;
  assign store_finish           = finish_q;
`ifdef FC2_ARGMAX_EN
  assign max_index              = max_index_q;
`endif

endmodule

// File: tb/tb_fc2_result_store.sv
// Directed bench for fc2_result_store: expected BRAM writes are queued when a store starts
// and popped by a write monitor; control timing is checked inline.
module tb_fc2_result_store;

  localparam int N    = 10;
  localparam int DW   = 8;
  localparam int BASE = 18900;
  localparam int AW   = 15;

  logic            clk;
  logic            rst;
  logic            store_en;
  logic [DW*N-1:0] data_in;
  logic            store_busy;
  logic            store_finish;
`ifdef FC2_ARGMAX_EN
  logic [3:0]      max_index;
`endif

  fc2_result_store_if #(.ADDR_W(AW), .DATA_SIZE(DW)) bram ();

  fc2_result_store #(
    .OUTPUT_NODE(N), .DATA_SIZE(DW), .FC2_RESULT_BASE(BASE), .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .store_en    (store_en),
    .data_in     (data_in),
    .bram        (bram),
    .store_busy  (store_busy),
    .store_finish(store_finish)
`ifdef FC2_ARGMAX_EN
    ,
    .max_index   (max_index)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] byte_of(input logic [DW*N-1:0] v, input int k);
    return v[DW*(N-k)-1 -: DW];
  endfunction

  function automatic logic [3:0] ref_argmax(input logic [DW*N-1:0] v);
    int best_i = 0;
    int best_v = $signed(byte_of(v, 0));
    for (int k = 1; k < N; k++) begin
      if ($signed(byte_of(v, k)) > best_v) begin
        best_v = $signed(byte_of(v, k));
        best_i = k;
      end
    end
    return 4'(best_i);
  endfunction

  task automatic push_vec(input logic [DW*N-1:0] v);
    wr_t e;
    for (int k = 0; k < N; k++) begin
      e.a = AW'(BASE + k);
      e.d = byte_of(v, k);
      sb.push_back(e);
    end
  endtask

  // Every write seen on the BRAM port must match the next queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1 && bram.result_bram_ena === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_write", 80'(bram.result_bram_ena), 80'(0));
      end else begin
        e = sb.pop_front();
        check("wr_addr", 80'(bram.result_bram_addra), 80'(e.a));
        check("wr_data", 80'(bram.result_bram_dina), 80'(e.d));
        check("wr_wea", 80'(bram.result_bram_wea), 80'(1));
      end
    end
  end

  task automatic run_store(input logic [DW*N-1:0] v, input bit corrupt);
    data_in = v;
    push_vec(v);
    store_en = 1'b1;
    tick();
    check("busy_latch", 80'(store_busy), 80'(1));
    check("ena_latch", 80'(bram.result_bram_ena), 80'(0));
    tick();
    if (corrupt) data_in = '1;
    check("ena_before_first", 80'(bram.result_bram_ena), 80'(0));
    for (int i = 0; i < N; i++) begin
      tick();
      check("ena_write", 80'(bram.result_bram_ena), 80'(1));
      check("busy_write", 80'(store_busy), 80'(1));
      check("finish_write", 80'(store_finish), 80'(0));
    end
    tick();
    check("finish_rise", 80'(store_finish), 80'(1));
    check("ena_done", 80'(bram.result_bram_ena), 80'(0));
    check("wea_done", 80'(bram.result_bram_wea), 80'(0));
    check("busy_done", 80'(store_busy), 80'(0));
    check("sb_drained", 80'(sb.size()), 80'(0));
`ifdef FC2_ARGMAX_EN
    check("max_index", 80'(max_index), 80'(ref_argmax(v)));
`endif
    tick();
    check("finish_hold", 80'(store_finish), 80'(1));
    store_en = 1'b0;
    tick();
    check("finish_fall", 80'(store_finish), 80'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW*N-1:0] v1, v2, v3, v4, vmax;
    v1   = 80'h0102030405060708090A;
    v2   = 80'hA1B2C3D4E5F60718293A;
    v3   = 80'h11223344556677889900;
    v4   = 80'hF0E0D0C0B0A090807060;
    vmax = 80'h05807F7F000000000000;

    rst = 1'b0;
    store_en = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ena", 80'(bram.result_bram_ena), 80'(0));
    check("rst_wea", 80'(bram.result_bram_wea), 80'(0));
    check("rst_addra", 80'(bram.result_bram_addra), 80'(0));
    check("rst_dina", 80'(bram.result_bram_dina), 80'(0));
    check("rst_busy", 80'(store_busy), 80'(0));
    check("rst_finish", 80'(store_finish), 80'(0));
`ifdef FC2_ARGMAX_EN
    check("rst_max_index", 80'(max_index), 80'(0));
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic store, then a store whose input changes after the latch.
    run_store(v1, 1'b0);
    tick();
    run_store(v1, 1'b1);
    tick();

    // Abort after the fourth write.
    data_in = v3;
    push_vec(v3);
    store_en = 1'b1;
    tick();
    tick();
    repeat (4) tick();
    store_en = 1'b0;
    tick();
    check("abort_ena", 80'(bram.result_bram_ena), 80'(0));
    check("abort_wea", 80'(bram.result_bram_wea), 80'(0));
    check("abort_busy", 80'(store_busy), 80'(0));
    check("abort_remaining", 80'(sb.size()), 80'(N - 4));
    sb.delete();
    repeat (3) begin
      tick();
      check("abort_no_finish", 80'(store_finish), 80'(0));
    end
    run_store(v3, 1'b0);
    tick();

    // Asynchronous reset during the sixth write.
    data_in = v4;
    push_vec(v4);
    store_en = 1'b1;
    tick();
    tick();
    repeat (6) tick();
    check("pre_rst_ena", 80'(bram.result_bram_ena), 80'(1));
    #2;
    rst = 1'b0;
    #1;
    check("arst_ena", 80'(bram.result_bram_ena), 80'(0));
    check("arst_wea", 80'(bram.result_bram_wea), 80'(0));
    check("arst_busy", 80'(store_busy), 80'(0));
    check("arst_finish", 80'(store_finish), 80'(0));
    check("arst_remaining", 80'(sb.size()), 80'(N - 5));
    sb.delete();
    store_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_idle", 80'(store_busy), 80'(0));
    run_store(v4, 1'b0);

    // Back-to-back stores with store_en low for one cycle between them.
    run_store(v2, 1'b0);
    run_store(vmax, 1'b0);
`ifdef FC2_ARGMAX_EN
    check("argmax_signed_tie", 80'(max_index), 80'(2));
`endif
    tick();
    check("final_sb_empty", 80'(sb.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
